// File: rtl/word_comparator_serial.sv
// word_comparator_serial
//   Serial MSB-first magnitude comparator for two WIDTH-bit words.
//   A start in IDLE captures Superior/Inferior (optionally inverted for
//   active-low switch inputs) and scans one bit per clock, stopping at the
//   first differing bit. Reports lt/eq/gt, the number of bits examined and
//   per-bit lt/eq/gt vectors latched at capture time.
//   Optional feature macro: CMP_SIGNED_EN (two's complement compare).
module word_comparator_serial #(
   parameter int WIDTH      = 8,
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [WIDTH-1:0]           sup,
   input  logic [WIDTH-1:0]           inf,
   output logic                       busy,
   output logic                       done,
   output logic                       lt,
   output logic                       eq,
   output logic                       gt,
   output logic [WIDTH-1:0]           bit_lt,
   output logic [WIDTH-1:0]           bit_eq,
   output logic [WIDTH-1:0]           bit_gt,
   output logic [$clog2(WIDTH+1)-1:0] nbits,
   output logic                       led
);

   localparam int NW = $clog2(WIDTH + 1);

   typedef enum logic {
      IDLE,
      RUN
   } state_e;

   state_e           state_q;
   logic [WIDTH-1:0] sup_sh_q;
   logic [WIDTH-1:0] inf_sh_q;
   logic [NW-1:0]    cnt_q;      // bits already examined in this compare
   logic [NW-1:0]    cnt_d;

   logic [WIDTH-1:0] sup_n;
   logic [WIDTH-1:0] inf_n;
   logic             s_bit;
   logic             i_bit;
   logic             bits_differ;
   logic             last_bit;
   logic             s_wins;     // Superior is greater at the current bit
   logic             capture;

   // Normalise inputs and decode the bit under examination.
   // NOTE: every always_comb output gets a value on every path, so no latch can be inferred.
   always_comb begin
      sup_n       = ACTIVE_LOW ? ~sup : sup;
      inf_n       = ACTIVE_LOW ? ~inf : inf;
      s_bit       = sup_sh_q[WIDTH-1];
      i_bit       = inf_sh_q[WIDTH-1];
      bits_differ = s_bit ^ i_bit;
      last_bit    = (cnt_q == NW'(WIDTH - 1));
      cnt_d       = cnt_q + 1'b1;
      capture     = (state_q == IDLE) && start;
`ifdef CMP_SIGNED_EN
      // The sign bit carries negative weight, so a set MSB means smaller.
      s_wins      = (cnt_q == '0) ? i_bit : s_bit;
`else
      s_wins      = s_bit;
`endif
   end

   // Operand shift registers: load on capture, shift left while scanning.
   // NOTE: pure datapath storage is deliberately left out of reset; it is always loaded before it is read.
   always_ff @(posedge clk) begin
      if (capture) begin
         sup_sh_q <= sup_n;
         inf_sh_q <= inf_n;
      end else if (state_q == RUN) begin
         sup_sh_q <= sup_sh_q << 1;
         inf_sh_q <= inf_sh_q << 1;
      end
   end

   // Control FSM with registered result outputs.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         lt      <= 1'b0;
         eq      <= 1'b0;
         gt      <= 1'b0;
         bit_lt  <= '0;
         bit_eq  <= '0;
         bit_gt  <= '0;
         nbits   <= '0;
      end else begin
         done <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= RUN;
                  cnt_q   <= '0;
                  busy    <= 1'b1;
                  bit_lt  <= ~sup_n & inf_n;
                  bit_eq  <= ~(sup_n ^ inf_n);
                  bit_gt  <= sup_n & ~inf_n;
               end
            end
            RUN: begin
               if (bits_differ) begin
                  lt      <= ~s_wins;
                  gt      <= s_wins;
                  eq      <= 1'b0;
                  nbits   <= cnt_d;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state_q <= IDLE;
               end else if (last_bit) begin
                  lt      <= 1'b0;
                  gt      <= 1'b0;
                  eq      <= 1'b1;
                  nbits   <= cnt_d;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state_q <= IDLE;
               end else begin
                  cnt_q   <= cnt_d;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign led = busy;

endmodule

// File: tb/tb_word_comparator_serial.sv
// tb_word_comparator_serial
//   Directed bench for word_comparator_serial: an 8-bit active-high
//   instance and a 3-bit active-low instance sharing clock and reset.
module tb_word_comparator_serial;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] sup;
   logic [7:0] inf;
   logic       busy, done, lt, eq, gt, led;
   logic [7:0] bit_lt, bit_eq, bit_gt;
   logic [3:0] nbits;

   logic       start3;
   logic [2:0] sup3;
   logic [2:0] inf3;
   logic       busy3, done3, lt3, eq3, gt3, led3;
   logic [2:0] bit_lt3, bit_eq3, bit_gt3;
   logic [1:0] nbits3;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   word_comparator_serial #(.WIDTH(8), .ACTIVE_LOW(1'b0)) dut8 (
      .clk(clk), .rst(rst), .start(start), .sup(sup), .inf(inf),
      .busy(busy), .done(done), .lt(lt), .eq(eq), .gt(gt),
      .bit_lt(bit_lt), .bit_eq(bit_eq), .bit_gt(bit_gt),
      .nbits(nbits), .led(led)
   );

   word_comparator_serial #(.WIDTH(3), .ACTIVE_LOW(1'b1)) dut3 (
      .clk(clk), .rst(rst), .start(start3), .sup(sup3), .inf(inf3),
      .busy(busy3), .done(done3), .lt(lt3), .eq(eq3), .gt(gt3),
      .bit_lt(bit_lt3), .bit_eq(bit_eq3), .bit_gt(bit_gt3),
      .nbits(nbits3), .led(led3)
   );

   // Advance one clock and settle just after the edge.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // After the capture edge: count cycles until done (bounded) and busy samples seen.
   task automatic wait_done8(input int max_cyc, output int cyc, output int busy_cyc);
      cyc      = 0;
      busy_cyc = 0;
      while (cyc < max_cyc) begin
         if (busy) busy_cyc++;
         tick();
         cyc++;
         if (done) break;
      end
   endtask

   // Capture sup/inf with a one-cycle start pulse.
   task automatic start8(input logic [7:0] s, input logic [7:0] i);
      sup   = s;
      inf   = i;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if ({busy, done, lt, eq, gt, led} !== 6'b0) begin
         failures++;
         $display("FAIL reset_flags got=%b exp=000000", {busy, done, lt, eq, gt, led});
      end
      checks++;
      if ({bit_lt, bit_eq, bit_gt, nbits} !== 28'h0) begin
         failures++;
         $display("FAIL reset_vectors got=%h exp=0", {bit_lt, bit_eq, bit_gt, nbits});
      end
      checks++;
      if ({busy3, done3, lt3, eq3, gt3, bit_lt3, bit_eq3, bit_gt3, nbits3} !== 16'h0) begin
         failures++;
         $display("FAIL reset_dut3 got=%h exp=0",
                  {busy3, done3, lt3, eq3, gt3, bit_lt3, bit_eq3, bit_gt3, nbits3});
      end
      rst = 1'b0;
      tick();
   endtask

   // 0x80 vs 0x7F: decided at the MSB.
   task automatic test_msb_diff;
      int   cyc, bc;
      logic exp_lt, exp_gt;
`ifdef CMP_SIGNED_EN
      exp_lt = 1'b1; exp_gt = 1'b0;
`else
      exp_lt = 1'b0; exp_gt = 1'b1;
`endif
      start8(8'h80, 8'h7F);
      checks++;
      if (bit_gt !== 8'h80 || bit_lt !== 8'h7F || bit_eq !== 8'h00) begin
         failures++;
         $display("FAIL msb_bitvec got lt=%h eq=%h gt=%h exp lt=7f eq=00 gt=80", bit_lt, bit_eq, bit_gt);
      end
      checks++;
      if (busy !== 1'b1 || led !== 1'b1 || done !== 1'b0) begin
         failures++;
         $display("FAIL msb_busy got busy=%b led=%b done=%b exp 1 1 0", busy, led, done);
      end
      wait_done8(12, cyc, bc);
      checks++;
      if (cyc !== 1 || done !== 1'b1) begin
         failures++;
         $display("FAIL msb_latency got=%0d done=%b exp=1", cyc, done);
      end
      checks++;
      if ({lt, eq, gt} !== {exp_lt, 1'b0, exp_gt} || nbits !== 4'd1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL msb_result got lt=%b eq=%b gt=%b nbits=%0d busy=%b exp lt=%b gt=%b nbits=1 busy=0",
                  lt, eq, gt, nbits, busy, exp_lt, exp_gt);
      end
      tick();
      checks++;
      if (done !== 1'b0 || {lt, eq, gt} !== {exp_lt, 1'b0, exp_gt}) begin
         failures++;
         $display("FAIL msb_hold got done=%b lt=%b gt=%b exp done=0 held result", done, lt, gt);
      end
   endtask

   // 0xFF vs 0x01: unsigned says greater, two's complement says less.
   task automatic test_signed_msb;
      int   cyc, bc;
      logic exp_lt, exp_gt;
`ifdef CMP_SIGNED_EN
      exp_lt = 1'b1; exp_gt = 1'b0;
`else
      exp_lt = 1'b0; exp_gt = 1'b1;
`endif
      start8(8'hFF, 8'h01);
      wait_done8(12, cyc, bc);
      checks++;
      if (cyc !== 1 || {lt, eq, gt} !== {exp_lt, 1'b0, exp_gt} || nbits !== 4'd1) begin
         failures++;
         $display("FAIL sign_msb got cyc=%0d lt=%b eq=%b gt=%b nbits=%0d exp cyc=1 lt=%b gt=%b nbits=1",
                  cyc, lt, eq, gt, nbits, exp_lt, exp_gt);
      end
      tick();
   endtask

   // 0xA5 vs 0xA5: full scan, equal.
   task automatic test_equal;
      int cyc, bc;
      start8(8'hA5, 8'hA5);
      checks++;
      if (bit_eq !== 8'hFF || bit_lt !== 8'h00 || bit_gt !== 8'h00) begin
         failures++;
         $display("FAIL eq_bitvec got lt=%h eq=%h gt=%h exp 00 ff 00", bit_lt, bit_eq, bit_gt);
      end
      wait_done8(12, cyc, bc);
      checks++;
      if (cyc !== 8 || bc !== 8) begin
         failures++;
         $display("FAIL eq_latency got cyc=%0d busy=%0d exp 8 8", cyc, bc);
      end
      checks++;
      if ({lt, eq, gt} !== 3'b010 || nbits !== 4'd8 || done !== 1'b1) begin
         failures++;
         $display("FAIL eq_result got lt=%b eq=%b gt=%b nbits=%0d done=%b exp 0 1 0 8 1",
                  lt, eq, gt, nbits, done);
      end
      tick();
   endtask

   // 0x12 vs 0x13 decided at the LSB, then a start in the done cycle.
   task automatic test_back_to_back;
      int cyc, bc;
      start8(8'h12, 8'h13);
      wait_done8(12, cyc, bc);
      checks++;
      if (cyc !== 8 || {lt, eq, gt} !== 3'b100 || nbits !== 4'd8) begin
         failures++;
         $display("FAIL lsb_result got cyc=%0d lt=%b eq=%b gt=%b nbits=%0d exp 8 1 0 0 8",
                  cyc, lt, eq, gt, nbits);
      end
      start8(8'h40, 8'h00);
      checks++;
      if (busy !== 1'b1 || bit_gt !== 8'h40) begin
         failures++;
         $display("FAIL b2b_accept got busy=%b bit_gt=%h exp 1 40", busy, bit_gt);
      end
      wait_done8(12, cyc, bc);
      checks++;
      if (cyc !== 2 || bc !== 2 || {lt, eq, gt} !== 3'b001 || nbits !== 4'd2) begin
         failures++;
         $display("FAIL b2b_result got cyc=%0d busy=%0d lt=%b eq=%b gt=%b nbits=%0d exp 2 2 0 0 1 2",
                  cyc, bc, lt, eq, gt, nbits);
      end
      tick();
   endtask

   // Restart attempt while busy, with changed operands: must be ignored.
   task automatic test_start_while_busy;
      int cyc, bc;
      start8(8'h00, 8'h01);
      tick();
      tick();
      sup   = 8'hFF;
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || bit_lt !== 8'h01) begin
         failures++;
         $display("FAIL busy_ignore got busy=%b done=%b bit_lt=%h exp 1 0 01", busy, done, bit_lt);
      end
      wait_done8(12, cyc, bc);
      checks++;
      if (cyc !== 5 || {lt, eq, gt} !== 3'b100 || nbits !== 4'd8) begin
         failures++;
         $display("FAIL busy_result got cyc=%0d lt=%b eq=%b gt=%b nbits=%0d exp 5 1 0 0 8",
                  cyc, lt, eq, gt, nbits);
      end
      tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL busy_idle got busy=%b done=%b exp 0 0", busy, done);
      end
   endtask

   // Reset in the middle of a scan abandons it silently.
   task automatic test_reset_midrun;
      start8(8'h01, 8'h00);
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      checks++;
      if ({busy, done, lt, eq, gt, led} !== 6'b0 || {bit_lt, bit_eq, bit_gt, nbits} !== 28'h0) begin
         failures++;
         $display("FAIL midrun_reset got flags=%b vec=%h exp 0 0",
                  {busy, done, lt, eq, gt, led}, {bit_lt, bit_eq, bit_gt, nbits});
      end
      rst = 1'b0;
      repeat (6) begin
         tick();
         checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midrun_nodone got done=%b busy=%b exp 0 0", done, busy);
         end
      end
   endtask

   // 3-bit active-low instance: 111/110 become 000/001.
   task automatic test_active_low;
      int cyc;
      sup3   = 3'b111;
      inf3   = 3'b110;
      start3 = 1'b1;
      tick();
      start3 = 1'b0;
      checks++;
      if (bit_lt3 !== 3'b001 || bit_eq3 !== 3'b110 || bit_gt3 !== 3'b000 || busy3 !== 1'b1) begin
         failures++;
         $display("FAIL al_bitvec got lt=%b eq=%b gt=%b busy=%b exp 001 110 000 1",
                  bit_lt3, bit_eq3, bit_gt3, busy3);
      end
      cyc = 0;
      while (cyc < 8) begin
         tick();
         cyc++;
         if (done3) break;
      end
      checks++;
      if (cyc !== 3 || {lt3, eq3, gt3} !== 3'b100 || nbits3 !== 2'd3) begin
         failures++;
         $display("FAIL al_result got cyc=%0d lt=%b eq=%b gt=%b nbits=%0d exp 3 1 0 0 3",
                  cyc, lt3, eq3, gt3, nbits3);
      end
      tick();
   endtask

   initial begin
      rst    = 1'b1;
      start  = 1'b0;
      sup    = 8'h00;
      inf    = 8'h00;
      start3 = 1'b0;
      sup3   = 3'b000;
      inf3   = 3'b000;
      #2;
      test_reset();
      test_msb_diff();
      test_signed_msb();
      test_equal();
      test_back_to_back();
      test_start_while_busy();
      test_reset_midrun();
      test_active_low();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
